// File: rtl/cpu_prog_sequencer_pkg.sv
// Shared types and constants for the program sequencer that feeds the 8-bit CPU.
package cpu_seq_pkg;

    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned CTRL_W_DEF = 6;
    localparam int unsigned DATA_W     = 8;

    localparam logic [1:0] OP_EXEC = 2'b00;
    localparam logic [1:0] OP_JMP  = 2'b01;
    localparam logic [1:0] OP_JC   = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    localparam int unsigned FLAG_C = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } seq_state_t;

    // Select one CPU status flag by the 2-bit JC selector (00=C, 01=Z, 10=V, 11=N).
    function automatic logic flag_sel(input logic [3:0] flags, input logic [1:0] sel);
        logic v;
        case (sel)
            2'b00:   v = flags[FLAG_C];
            2'b01:   v = flags[FLAG_Z];
            2'b10:   v = flags[FLAG_V];
            default: v = flags[FLAG_N];
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cpu_prog_sequencer_if.sv
// Load/control/status bundle between the top level and the program sequencer.
interface cpu_prog_sequencer_if
    import cpu_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned CTRL_W = CTRL_W_DEF
);
    logic              load_en_i;
    logic [ADDR_W-1:0] load_addr_i;
    logic [7:0]        load_data_i;
    logic              run_i;
    logic              step_i;
    logic              restart_i;
    logic [3:0]        flags_i;
    logic [CTRL_W-1:0] ctrl_o;
    logic              ctrl_valid_o;
    logic [ADDR_W-1:0] pc_o;
    logic              halted_o;

    modport master (
        output load_en_i, load_addr_i, load_data_i, run_i, step_i, restart_i, flags_i,
        input  ctrl_o, ctrl_valid_o, pc_o, halted_o
    );

    modport slave (
        input  load_en_i, load_addr_i, load_data_i, run_i, step_i, restart_i, flags_i,
        output ctrl_o, ctrl_valid_o, pc_o, halted_o
    );
endinterface

// File: rtl/cpu_prog_store.sv
// Program store: flop array with synchronous write, combinational read, cleared on reset.
module cpu_prog_store
    import cpu_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Reset fills every word with EXEC NOP; otherwise accept one write per cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/cpu_prog_sequencer.sv
// Program sequencer: holds a small control-word program and issues it to the CPU core.
module cpu_prog_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned CTRL_W = CTRL_W_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    cpu_prog_sequencer_if.slave  bus
);
    seq_state_t        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_valid;

    logic [DATA_W-1:0] w_word;
    logic [1:0]        w_op;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_exec_pc;
    logic [CTRL_W-1:0] w_exec_ctrl;
    logic              w_exec_valid;
    logic              w_exec_halt;
    logic              w_load_ok;

    // Loads are taken in HALTED, and in IDLE unless a restart outranks them.
    assign w_load_ok = bus.load_en_i &&
                       (((r_state == ST_IDLE) && !bus.restart_i) || (r_state == ST_HALTED));

    cpu_prog_store #(.ADDR_W(ADDR_W)) u_store (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .i_wr_en   (w_load_ok),
        .i_wr_addr (bus.load_addr_i),
        .i_wr_data (bus.load_data_i),
        .i_rd_addr (r_pc),
        .o_rd_data (w_word)
    );

    assign w_op     = w_word[7:6];
    assign w_target = w_word[ADDR_W-1:0];
    assign w_pc_inc = ADDR_W'(r_pc + 1'b1);

    // Decode mem[pc] into the results an execute cycle would register.
    always_comb begin
        w_exec_pc    = w_pc_inc;
        w_exec_ctrl  = '0;
        w_exec_valid = 1'b0;
        w_exec_halt  = 1'b0;
        case (w_op)
            OP_EXEC: begin
                w_exec_ctrl  = w_word[CTRL_W-1:0];
                w_exec_valid = 1'b1;
            end
            OP_JMP:  w_exec_pc = w_target;
            OP_JC:   w_exec_pc = flag_sel(bus.flags_i, w_word[5:4]) ? w_target : w_pc_inc;
            default: begin
                w_exec_pc   = r_pc;
                w_exec_halt = 1'b1;
            end
        endcase
    end

    // Sequencer FSM with pc and registered control outputs; non-execute cycles issue zero.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_ctrl  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_ctrl  <= '0;
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.restart_i) begin
                        r_pc <= '0;
                    end else if (bus.load_en_i) begin
                        r_pc <= r_pc;
                    end else if (bus.step_i) begin
                        r_pc    <= w_exec_pc;
                        r_ctrl  <= w_exec_ctrl;
                        r_valid <= w_exec_valid;
                        if (w_exec_halt) r_state <= ST_HALTED;
                    end else if (bus.run_i) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!bus.run_i) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_pc    <= w_exec_pc;
                        r_ctrl  <= w_exec_ctrl;
                        r_valid <= w_exec_valid;
                        if (w_exec_halt) r_state <= ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    if (bus.restart_i) begin
                        r_pc    <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ctrl_o       = r_ctrl;
    assign bus.ctrl_valid_o = r_valid;
    assign bus.pc_o         = r_pc;
    assign bus.halted_o     = (r_state == ST_HALTED);
endmodule

// File: doc/cpu_prog_sequencer.md
Name: cpu_prog_sequencer

Overview:
- Upstream feeder for the 8-bit CPU core: holds a small program of control words and issues one 6-bit control word per cycle on the CPU's external control input.
- Consumes the CPU status flags (C, Z, V, N) to resolve conditional jumps.
- Program is loaded serially by address/data writes while the sequencer is not running.
- Supports run, single-step and halt, so the top level can drive the CPU autonomously instead of from raw pins.

Parameters:
- ADDR_W, 4, program address width; DEPTH = 2**ADDR_W words.
- CTRL_W, 6, width of the control word issued to the CPU.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset; synchronous, active-low.
- load_en_i  in  1  write enable into the program store.
- load_addr_i  in  ADDR_W  program store write address.
- load_data_i  in  8  program word to write.
- run_i  in  1  level: continuous execution while high.
- step_i  in  1  single-cycle pulse: execute exactly one word.
- restart_i  in  1  pulse: pc to 0, leave HALTED.
- flags_i  in  4  CPU status, [3]=C [2]=Z [1]=V [0]=N, registered in the CPU.
- ctrl_o  out  CTRL_W  control word to the CPU.
- ctrl_valid_o  out  1  ctrl_o carries an issued EXEC word this cycle.
- pc_o  out  ADDR_W  current program counter.
- halted_o  out  1  sequencer is in HALTED.

Behaviour:
- Program word format, bits [7:6]:
  - 00 EXEC: issue [5:0].
  - 01 JMP: jump to [ADDR_W-1:0].
  - 10 JC: flag select [5:4] (00=C, 01=Z, 10=V, 11=N); jump to [ADDR_W-1:0] if that flag is 1, else pc+1.
  - 11 HALT.
- Program store: DEPTH x 8 flops, synchronous write, combinational read of mem[pc]. Reset clears every word to 8'h00 (EXEC NOP).
- States: IDLE, RUN, HALTED.
- Reset:
  - state=IDLE, pc=0, ctrl_o=0, ctrl_valid_o=0, halted_o=0.
  - Reset mid-run aborts at the next edge. No partial word is issued.
- Execute cycle (RUN, or IDLE with step_i), decoding mem[pc]. All results are registered, giving one-cycle latency from pc to ctrl_o.
  - EXEC: ctrl_o<=[5:0], ctrl_valid_o<=1, pc<=pc+1 (wraps DEPTH-1 -> 0).
  - JMP/JC: ctrl_o<=0, ctrl_valid_o<=0, pc<=target or pc+1.
  - JC samples flags_i in the decode cycle.
  - HALT: ctrl_o<=0, ctrl_valid_o<=0, pc held, state<=HALTED.
- Cycles that do not execute: ctrl_o<=0 and ctrl_valid_o<=0, so no control word is ever repeated.
- Transitions:
  - IDLE -> RUN when run_i=1 and load_en_i=0.
  - RUN -> IDLE when run_i=0 (no execute that cycle).
  - HALTED -> IDLE on restart_i (pc<=0).
  - restart_i in IDLE sets pc<=0.
  - restart_i in RUN is ignored.
- Priority in IDLE: restart_i > load_en_i > step_i > run_i.
  - Load wins over run; run begins the following cycle if still high.
  - step_i while load_en_i=1 is dropped.
- load_en_i is ignored in RUN. It is accepted in IDLE and HALTED.
- step_i is ignored in RUN and HALTED. In HALTED, run_i has no effect until restart_i.
- halted_o = (state==HALTED).

Decomposition:
- Shared package cpu_seq_pkg holds:
  - opcode constants OP_EXEC, OP_JMP, OP_JC, OP_HALT.
  - flag index constants FLAG_C=3, FLAG_Z=2, FLAG_V=1, FLAG_N=0.
  - state enum seq_state_t.
- One natural sub-module: cpu_prog_store (flop array, sync write, async read, sync clear). FSM, pc and decode stay in the top.

Test Plan:
- Load [0]=8'h05, [1]=8'h2A, [2]=8'hC0, then run_i=1 -> ctrl_o/valid sequence 05/1, 2A/1, then 00/0 with halted_o=1 and pc_o=2.
- Load [0]=8'h01, [1]=8'h40 (JMP 0), run 6 cycles -> ctrl_valid_o alternates 1,0,1,0; ctrl_o=01 on valid cycles.
- Load [0]=8'h90 (JC Z to 0), [1]=8'hC0, flags_i=4'b0100, run -> pc stays 0. Then flags_i=0 -> pc 1, then HALTED.
- DEPTH=16 all-EXEC program, run 17 cycles -> pc_o wraps 15 -> 0 and the word at 0 is reissued.
- In IDLE, pulse step_i three times on [0..2]=8'h11,8'h12,8'h13 -> exactly one valid cycle per pulse. Then load_en_i while run_i=1 -> load applied, run starts next cycle.
- Assert rst_ni=0 mid-run for one cycle -> next edge: pc_o=0, ctrl_o=0, valid=0, IDLE, memory words read back 8'h00.
